// File: rtl/norm_pkg.sv
// Shared definitions for the normalisation path: pixel width, writer FSM states,
// and a max helper.
package norm_pkg;
  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCANNING = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } norm_state_e;

  function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/norm_denom_writer_if.sv
// Control handshake, pixel streams and denominator result of norm_denom_writer.
// The slave modport is the block's view; master is the driver/bench view.
interface norm_denom_writer_if;
  import norm_pkg::*;

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [PIX_W-1:0] s_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [PIX_W-1:0] m_axis_tdata;
  logic [PIX_W-1:0] norm_denominator;
  logic             norm_denominator_tvalid;

  modport slave (
    input  ap_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tdata,
           norm_denominator, norm_denominator_tvalid
  );

  modport master (
    output ap_start, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tdata,
           norm_denominator, norm_denominator_tvalid
  );
endinterface

// File: rtl/axis_skid_buffer.sv
// 2-entry stream buffer: registered outputs, 1-cycle latency, full throughput,
// and upstream ready depends only on occupancy (never on downstream ready).
module axis_skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_empty
);
  logic [1:0][DATA_W-1:0] r_mem;
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   w_push;
  logic                   w_pop;

  assign o_s_ready = (r_count != 2'd2);
  assign o_m_valid = (r_count != 2'd0);
  assign o_empty   = (r_count == 2'd0);
  assign o_m_data  = r_mem[r_rd_ptr];
  assign w_push    = i_s_valid & o_s_ready;
  assign w_pop     = o_m_valid & i_m_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_s_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/norm_denom_writer.sv
// Passes one cropped frame through unchanged while tracking its maximum pixel,
// then publishes that maximum (never 0) as the normalisation divisor.
module norm_denom_writer
  import norm_pkg::*;
#(
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
) (
  input  logic               clk,
  input  logic               s_axis_resetn,
  norm_denom_writer_if.slave bus
);
  localparam int N     = OUT_ROWS * OUT_COLS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  norm_state_e      r_state;
  norm_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PIX_W-1:0] r_max;
  logic [PIX_W-1:0] r_nd;
  logic             r_nd_vld;
  logic             r_done;
  logic             w_skid_in_ready;
  logic             w_skid_empty;
  logic             w_s_tready;
  logic             w_accept;
  logic             w_start;
  logic             w_finish;

  // Assert immediately, release two clocks later so every flop leaves reset together.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_s_tready = (r_state == SCANNING) && w_skid_in_ready;
  assign w_accept   = bus.s_axis_tvalid && w_s_tready;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.ap_start) begin
          w_start     = 1'b1;
          w_state_nxt = SCANNING;
        end
      end
      SCANNING: begin
        // Leaving SCANNING on the last beat drops tready on the same edge.
        if (w_accept && (r_cnt == LAST_IDX)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_skid_empty) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt    <= '0;
      r_max    <= '0;
      r_nd     <= '0;
      r_nd_vld <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_cnt    <= '0;
        r_max    <= '0;
        r_nd_vld <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_max <= pix_max(r_max, bus.s_axis_tdata);
      end
      // An all-zero frame still yields a usable divisor.
      if (w_finish) begin
        r_nd     <= (r_max == '0) ? PIX_W'(1) : r_max;
        r_nd_vld <= 1'b1;
      end
    end
  end

  axis_skid_buffer #(
    .DATA_W (PIX_W)
  ) u_skid (
    .i_clk     (clk),
    .i_rst_n   (w_rst_n),
    .i_s_valid (w_accept),
    .o_s_ready (w_skid_in_ready),
    .i_s_data  (bus.s_axis_tdata),
    .o_m_valid (bus.m_axis_tvalid),
    .i_m_ready (bus.m_axis_tready),
    .o_m_data  (bus.m_axis_tdata),
    .o_empty   (w_skid_empty)
  );

  assign bus.s_axis_tready           = w_s_tready;
  assign bus.ap_ready                = (r_state == IDLE) || (r_state == DONE);
  assign bus.ap_done                 = r_done;
  assign bus.norm_denominator        = r_nd;
  assign bus.norm_denominator_tvalid = r_nd_vld;
endmodule

// File: tb/tb_norm_denom_writer.sv
// Scoreboard bench for norm_denom_writer with a 2x2 frame: stimulus pushes expected
// beats/divisors, monitors pop and compare on m_axis handshakes and ap_done.
module tb_norm_denom_writer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  bit   bp_mode = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  logic [7:0] exp_pix[$];
  logic [7:0] exp_nd[$];

  norm_denom_writer_if ifc();

  norm_denom_writer #(.OUT_ROWS(2), .OUT_COLS(2)) dut (
    .clk           (clk),
    .s_axis_resetn (rstn),
    .bus           (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pass-through scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
        if (exp_pix.size() == 0) chk("unexpected_beat", ifc.m_axis_tdata, 9999);
        else chk("beat_data", ifc.m_axis_tdata, exp_pix.pop_front());
      end
    end
  end

  // Frame-result scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.ap_done) begin
        done_cnt++;
        chk("done_all_beats_out", exp_pix.size(), 0);
        chk("done_nd_tvalid", ifc.norm_denominator_tvalid, 1);
        if (exp_nd.size() == 0) chk("unexpected_done", ifc.norm_denominator, 9999);
        else chk("norm_denominator", ifc.norm_denominator, exp_nd.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode) ifc.m_axis_tready = ~ifc.m_axis_tready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_frame();
    ifc.ap_start = 1'b1;
    @(posedge clk); #1;
    ifc.ap_start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit lat);
    bit ok = 1'b0;
    ifc.s_axis_tvalid = 1'b1;
    ifc.s_axis_tdata  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.s_axis_tready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      exp_pix.push_back(d);
      if (lat) begin
        chk("lat_m_tvalid", ifc.m_axis_tvalid, 1);
        chk("lat_m_tdata", ifc.m_axis_tdata, d);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input bit lat);
    send_beat(a, lat); send_beat(b, lat); send_beat(c, lat); send_beat(d, lat);
    ifc.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= target) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    if (!ok) chk("done_timeout", done_cnt, target);
  endtask

  initial begin
    int d0;
    ifc.ap_start = 1'b0;
    ifc.s_axis_tvalid = 1'b0;
    ifc.s_axis_tdata = 8'd0;
    ifc.m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ap_ready", ifc.ap_ready, 1);
    chk("rst_ap_done", ifc.ap_done, 0);
    chk("rst_m_tvalid", ifc.m_axis_tvalid, 0);
    chk("rst_s_tready", ifc.s_axis_tready, 0);
    chk("rst_nd", ifc.norm_denominator, 0);
    chk("rst_nd_tvalid", ifc.norm_denominator_tvalid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Nominal frame
    d0 = done_cnt;
    exp_nd.push_back(8'd200);
    start_frame();
    chk("scan_ap_ready", ifc.ap_ready, 0);
    send_frame(8'd10, 8'd200, 8'd37, 8'd5, 1'b1);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("nominal_done_once", done_cnt, d0 + 1);
    chk("done_ap_ready", ifc.ap_ready, 1);
    chk("done_hold_nd", ifc.norm_denominator, 200);
    chk("done_hold_tvalid", ifc.norm_denominator_tvalid, 1);

    // All-zero frame
    d0 = done_cnt;
    exp_nd.push_back(8'd1);
    start_frame();
    send_frame(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    wait_done(d0 + 1);
    @(posedge clk); #1;

    // Max on last beat under alternating backpressure
    d0 = done_cnt;
    exp_nd.push_back(8'd255);
    bp_mode = 1'b1;
    start_frame();
    send_frame(8'd1, 8'd2, 8'd3, 8'd255, 1'b0);
    wait_done(d0 + 1);
    bp_mode = 1'b0;
    @(posedge clk); #2;
    ifc.m_axis_tready = 1'b1;
    chk("bp_done_once", done_cnt, d0 + 1);

    // Overrun, with a stray ap_start mid-frame
    d0 = done_cnt;
    exp_nd.push_back(8'd50);
    start_frame();
    send_beat(8'd50, 1'b0);
    send_beat(8'd7, 1'b0);
    ifc.ap_start = 1'b1;
    send_beat(8'd9, 1'b0);
    ifc.ap_start = 1'b0;
    send_beat(8'd3, 1'b0);
    ifc.s_axis_tdata = 8'd111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("overrun_tready_low", ifc.s_axis_tready, 0);
    end
    wait_done(d0 + 1);
    ifc.s_axis_tdata = 8'd222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_tready_low", ifc.s_axis_tready, 0);
    end
    @(posedge clk); #1;
    ifc.s_axis_tvalid = 1'b0;
    chk("overrun_done_once", done_cnt, d0 + 1);

    // Back-to-back: A (max 90) then B (max 40), restarted from DONE
    d0 = done_cnt;
    exp_nd.push_back(8'd90);
    start_frame();
    chk("restart_s_tready", ifc.s_axis_tready, 1);
    send_frame(8'd90, 8'd12, 8'd3, 8'd4, 1'b0);
    wait_done(d0 + 1);
    @(posedge clk); #1;
    exp_nd.push_back(8'd40);
    ifc.ap_start = 1'b1;
    @(negedge clk);
    chk("b2b_tvalid_before", ifc.norm_denominator_tvalid, 1);
    @(posedge clk); #1;
    ifc.ap_start = 1'b0;
    chk("b2b_tvalid_dropped", ifc.norm_denominator_tvalid, 0);
    chk("b2b_ap_ready", ifc.ap_ready, 0);
    send_frame(8'd40, 8'd1, 8'd2, 8'd3, 1'b0);
    wait_done(d0 + 2);
    @(posedge clk); #1;

    // Async reset mid-frame
    ifc.m_axis_tready = 1'b0;
    start_frame();
    send_beat(8'd99, 1'b0);
    send_beat(8'd77, 1'b0);
    ifc.s_axis_tvalid = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("arst_ap_ready", ifc.ap_ready, 1);
    chk("arst_ap_done", ifc.ap_done, 0);
    chk("arst_m_tvalid", ifc.m_axis_tvalid, 0);
    chk("arst_s_tready", ifc.s_axis_tready, 0);
    chk("arst_nd", ifc.norm_denominator, 0);
    chk("arst_nd_tvalid", ifc.norm_denominator_tvalid, 0);
    exp_pix.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    ifc.m_axis_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    d0 = done_cnt;
    exp_nd.push_back(8'd8);
    start_frame();
    send_frame(8'd4, 8'd8, 8'd2, 8'd1, 1'b0);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    #1;

    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("nd_queue_empty", exp_nd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
